step_pulse_gen: RTL and testbench
=================================

Name: step_pulse_gen

Overview:
- Multi-channel, parametrised step/dir pulse generator for the FPGA stepper path.
- Each channel emits a programmed number of square step pulses at a programmed half-period, with a direction setup delay.
- Adds start/busy/done handshake, abort, reject flag and remaining-count readback.
- Sits between the HPS-facing register block and the motor-driver pins.

Parameters:
NUM_CH, 4, number of independent step channels
PERIOD_W, 32, width of half-period value in clk cycles
COUNT_W, 31, width of step count
DIR_SETUP, 2, clk cycles dir must be stable before the first step rising edge (0 allowed)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  NUM_CH  per-channel load strobe, sampled on posedge clk
abort  input  NUM_CH  per-channel abort strobe
dir_in  input  NUM_CH  direction to latch on start
period  input  NUM_CH*PERIOD_W  half-period per channel, channel k at [k*PERIOD_W +: PERIOD_W]
count  input  NUM_CH*COUNT_W  number of steps per channel, packed likewise
step_out  output  NUM_CH  step pulse to driver
dir_out  output  NUM_CH  latched direction to driver
busy  output  NUM_CH  channel running
done  output  NUM_CH  1-cycle pulse on normal completion
aborted  output  NUM_CH  1-cycle pulse on abort of a busy channel
reject  output  NUM_CH  1-cycle pulse when start arrives while busy
remaining  output  NUM_CH*COUNT_W  steps not yet completed

Behaviour:
- Reset (async, any time): all outputs 0, all channels IDLE, latched period/count/dir cleared.
- Channels are fully independent. Identical start edges give cycle-aligned outputs.
- Per-channel FSM states: IDLE, SETUP, HIGH, LOW.
- IDLE with start=1 and abort=0 at edge t:
  - latch dir_in, period, count. Effective period = max(period,1).
  - dir_out updates at t. busy=1 from t.
  - count=0: no SETUP. done=1 and busy=0 in cycle t+1, no step pulses.
  - count>0: SETUP lasts DIR_SETUP cycles, skipped if DIR_SETUP=0.
  - step_out rises at edge t+1+DIR_SETUP.
- HIGH: step_out=1 for P cycles, then LOW.
- LOW: step_out=0 for P cycles. At the end of LOW, remaining decrements.
  - remaining != 0 after decrement: go to HIGH.
  - remaining = 0: go to IDLE. done=1 for one cycle and busy=0 in that same cycle.
- Total: done asserted in cycle t+1+DIR_SETUP+2*P*count.
- remaining = latched count from t and decrements at each LOW end. It holds its value after abort and reads 0 after done.
- start while busy: ignored, reject=1 next cycle, no change to the run.
- abort while busy (any non-IDLE state): next cycle IDLE, step_out=0, busy=0, aborted=1, done=0.
- abort in IDLE: no effect, no pulse. This also applies when start and abort arrive together on an IDLE channel: abort wins, start is dropped, no reject.
- dir_out holds its last latched value while idle. It never changes while busy.
- Down-counters:
  - phase counter is PERIOD_W bits, loaded P-1, transition at 0. No wrap: P=2^PERIOD_W-1 is legal.
  - step counter is COUNT_W bits. Max count 2^COUNT_W-1 is legal.
- done, aborted and reject are mutually exclusive per channel per cycle.

Decomposition:
- Package step_pulse_pkg:
  - FSM state enum (IDLE, SETUP, HIGH, LOW), 2-bit encoding.
  - localparam for the minimum effective period (1).
- Sub-module step_pulse_chan: one channel FSM plus counters, parameterised by PERIOD_W, COUNT_W, DIR_SETUP.
- Top level instantiates NUM_CH copies in a generate loop and packs/unpacks the buses.

Test Plan:
1. Ch0 start, period=3, count=2, dir=1 at t=0 (DIR_SETUP=2) -> dir_out[0]=1 at t=0; step high t=3..5, low t=6..8, high t=9..11, low t=12..14; done[0] at t=15; remaining 2→1 at t=9, 0 at t=15.
2. Ch1 start, count=0 -> no step edges; done[1] and busy[1]=0 at t+1.
3. Ch2 period=0, count=3 -> treated as P=1: step toggles every cycle, 3 rising edges, done at t+1+2+6.
4. Ch3 running with count=10, start pulse mid-run -> reject[3] 1 cycle, run unchanged, done at original cycle. Then abort after 4 completed steps -> aborted[3] next cycle, step_out[3]=0, remaining=6, no done.
5. All 4 channels started in the same cycle with different periods (1,2,5,7), count=4 -> each done time matches formula independently. Simultaneous start+abort on an idle channel -> nothing happens.
6. Assert reset mid-HIGH phase asynchronously -> step_out, busy and remaining go 0 immediately without a clk edge. After release, a fresh start behaves as in scenario 1.

Source files
------------

// File: rtl/step_pulse_pkg.sv
// Shared types for the step/dir pulse generator: channel FSM states and
// the floor applied to the programmed half-period.
package step_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam int MIN_PERIOD = 1;

endpackage

// File: rtl/step_pulse_chan.sv
// One step/dir channel: latches a job on start, waits out the direction
// setup time, then emits count square pulses of 2*P cycles each.
module step_pulse_chan
  import step_pulse_pkg::*;
#(
  parameter int PERIOD_W  = 32,
  parameter int COUNT_W   = 31,
  parameter int DIR_SETUP = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                dir_in,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  count,
  output logic                step_out,
  output logic                dir_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                reject,
  output logic [COUNT_W-1:0]  remaining
);

  state_t state_reg, state_next;
  logic [PERIOD_W-1:0] phase_reg, phase_next;
  logic [PERIOD_W-1:0] half_reg, half_next;
  logic [COUNT_W-1:0]  remaining_reg, remaining_next;
  logic dir_reg, dir_next;
  logic step_reg, busy_reg;
  logic done_reg, done_next;
  logic aborted_reg, aborted_next;
  logic reject_reg, reject_next;
  logic run_end;

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    half_next      = half_reg;
    remaining_next = remaining_reg;
    dir_next       = dir_reg;
    done_next      = 1'b0;
    aborted_next   = 1'b0;
    reject_next    = 1'b0;
    run_end        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          dir_next       = dir_in;
          half_next      = (period < PERIOD_W'(MIN_PERIOD)) ? '0 : period - PERIOD_W'(1);
          remaining_next = count;
          // SETUP always occupies one cycle plus DIR_SETUP extra cycles
          phase_next     = PERIOD_W'(DIR_SETUP);
          state_next     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (remaining_reg == '0) begin
          state_next = ST_IDLE;
          run_end    = 1'b1;
        end else if (phase_reg == '0) begin
          state_next = ST_HIGH;
          phase_next = half_reg;
        end else begin
          phase_next = phase_reg - PERIOD_W'(1);
        end
      end
      ST_HIGH: begin
        if (phase_reg == '0) begin
          state_next = ST_LOW;
          phase_next = half_reg;
        end else begin
          phase_next = phase_reg - PERIOD_W'(1);
        end
      end
      ST_LOW: begin
        if (phase_reg == '0) begin
          remaining_next = remaining_reg - COUNT_W'(1);
          if (remaining_reg == COUNT_W'(1)) begin
            state_next = ST_IDLE;
            run_end    = 1'b1;
          end else begin
            state_next = ST_HIGH;
            phase_next = half_reg;
          end
        end else begin
          phase_next = phase_reg - PERIOD_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort beats completion, completion beats a late start, keeping the
    // three status pulses mutually exclusive.
    if (state_reg != ST_IDLE) begin
      if (abort) begin
        state_next     = ST_IDLE;
        remaining_next = remaining_reg;
        aborted_next   = 1'b1;
      end else if (run_end) begin
        done_next = 1'b1;
      end else if (start) begin
        reject_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= '0;
      half_reg      <= '0;
      remaining_reg <= '0;
      dir_reg       <= 1'b0;
      step_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
      reject_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      half_reg      <= half_next;
      remaining_reg <= remaining_next;
      dir_reg       <= dir_next;
      step_reg      <= (state_next == ST_HIGH);
      busy_reg      <= (state_next != ST_IDLE);
      done_reg      <= done_next;
      aborted_reg   <= aborted_next;
      reject_reg    <= reject_next;
    end
  end

  assign step_out  = step_reg;
  assign dir_out   = dir_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign aborted   = aborted_reg;
  assign reject    = reject_reg;
  assign remaining = remaining_reg;

endmodule

// File: rtl/step_pulse_gen.sv
// Multi-channel step/dir generator: NUM_CH independent channels sharing
// one clock, with packed per-channel period/count/remaining buses.
module step_pulse_gen #(
  parameter int NUM_CH    = 4,
  parameter int PERIOD_W  = 32,
  parameter int COUNT_W   = 31,
  parameter int DIR_SETUP = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH-1:0]            abort,
  input  logic [NUM_CH-1:0]            dir_in,
  input  logic [NUM_CH*PERIOD_W-1:0]   period,
  input  logic [NUM_CH*COUNT_W-1:0]    count,
  output logic [NUM_CH-1:0]            step_out,
  output logic [NUM_CH-1:0]            dir_out,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  output logic [NUM_CH-1:0]            aborted,
  output logic [NUM_CH-1:0]            reject,
  output logic [NUM_CH*COUNT_W-1:0]    remaining
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      step_pulse_chan #(
        .PERIOD_W (PERIOD_W),
        .COUNT_W  (COUNT_W),
        .DIR_SETUP(DIR_SETUP)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .start    (start[gi]),
        .abort    (abort[gi]),
        .dir_in   (dir_in[gi]),
        .period   (period[gi*PERIOD_W +: PERIOD_W]),
        .count    (count[gi*COUNT_W +: COUNT_W]),
        .step_out (step_out[gi]),
        .dir_out  (dir_out[gi]),
        .busy     (busy[gi]),
        .done     (done[gi]),
        .aborted  (aborted[gi]),
        .reject   (reject[gi]),
        .remaining(remaining[gi*COUNT_W +: COUNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: a job-timeline model predicts every output each
// cycle; directed scenarios add hand-computed literal checks.
module tb_step_pulse_gen;
  localparam int NCH = 4;
  localparam int PW  = 32;
  localparam int CW  = 31;
  localparam int DS  = 2;
  localparam int NEVER = 32'h3fffffff;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NCH-1:0] start = '0, abort = '0, dir_in = '0;
  logic [NCH*PW-1:0] period = '0;
  logic [NCH*CW-1:0] count = '0;
  logic [NCH-1:0] step_out, dir_out, busy, done, aborted, reject;
  logic [NCH*CW-1:0] remaining;

  int cyc = 0, rst_cyc = 0, chk_cnt = 0, pass_cnt = 0;
  int run_t[NCH][8], run_p[NCH][8], run_n[NCH][8], run_ab[NCH][8];
  logic run_d[NCH][8];
  int nrun[NCH] = '{default: 0};
  int rej_c[NCH][8];
  int nrej[NCH] = '{default: 0};
  int cfg_p[NCH], cfg_n[NCH];
  logic cfg_d[NCH];

  step_pulse_gen #(.NUM_CH(NCH), .PERIOD_W(PW), .COUNT_W(CW), .DIR_SETUP(DS)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .dir_in(dir_in),
    .period(period), .count(count), .step_out(step_out), .dir_out(dir_out),
    .busy(busy), .done(done), .aborted(aborted), .reject(reject), .remaining(remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s ch%0d cyc=%0d got %h want %h", name, ch, cyc, act, exp);
  endtask

  // Vector layout: {step, dir, busy, done, aborted, reject, remaining[30:0]}
  function automatic logic [63:0] model(input int ch, input int c);
    int idx = -1;
    int t, p, n, ab, e, stop, k, cref, comp;
    bit abd;
    logic st, bz, dn, ao, rj;
    logic [CW-1:0] rem;
    rj = 1'b0;
    for (int i = 0; i < nrej[ch]; i++)
      if (rej_c[ch][i] == c && rej_c[ch][i] > rst_cyc) rj = 1'b1;
    for (int i = 0; i < nrun[ch]; i++)
      if (run_t[ch][i] <= c && run_t[ch][i] > rst_cyc) idx = i;
    if (idx < 0) return {27'b0, 5'b0, rj, 31'b0};
    t = run_t[ch][idx]; p = run_p[ch][idx]; n = run_n[ch][idx]; ab = run_ab[ch][idx];
    e = (n == 0) ? t + 1 : t + 1 + DS + 2 * p * n;
    abd = (ab <= e);
    stop = abd ? ab : e;
    bz = (c < stop);
    dn = !abd && (c == e);
    ao = abd && (c == ab);
    k = c - (t + 1 + DS);
    st = bz && (k >= 0) && ((k % (2 * p)) < p);
    cref = abd ? ((c < ab - 1) ? c : ab - 1) : ((c < e) ? c : e);
    comp = (cref - (t + 1 + DS) >= 0) ? (cref - (t + 1 + DS)) / (2 * p) : 0;
    if (comp > n) comp = n;
    rem = CW'(n - comp);
    return {27'b0, st, run_d[ch][idx], bz, dn, ao, rj, rem};
  endfunction

  function automatic logic [63:0] actual(input int ch);
    return {27'b0, step_out[ch], dir_out[ch], busy[ch], done[ch], aborted[ch], reject[ch],
            remaining[ch*CW +: CW]};
  endfunction

  always @(negedge clk) begin
    if (reset)
      check("reset_all", -1, 64'(|{step_out, dir_out, busy, done, aborted, reject, remaining}), 64'd0);
    else
      for (int ch = 0; ch < NCH; ch++) check("cycle", ch, actual(ch), model(ch, cyc));
  end

  task automatic cfg(input int ch, input int p, input int n, input logic d);
    period[ch*PW +: PW] = PW'(p);
    count[ch*CW +: CW]  = CW'(n);
    dir_in[ch] = d;
    cfg_p[ch] = (p < 1) ? 1 : p;
    cfg_n[ch] = n;
    cfg_d[ch] = d;
  endtask

  // Called at a negedge; inputs are sampled on the following edge.
  task automatic strobe(input logic [NCH-1:0] st, input logic [NCH-1:0] ab);
    int e;
    logic [63:0] m;
    e = cyc + 1;
    for (int ch = 0; ch < NCH; ch++) begin
      m = model(ch, cyc);
      if (ab[ch]) begin
        if (m[34]) run_ab[ch][nrun[ch]-1] = e;
      end else if (st[ch]) begin
        if (m[34]) begin
          rej_c[ch][nrej[ch]] = e;
          nrej[ch]++;
        end else begin
          run_t[ch][nrun[ch]] = e;  run_p[ch][nrun[ch]] = cfg_p[ch];
          run_n[ch][nrun[ch]] = cfg_n[ch]; run_d[ch][nrun[ch]] = cfg_d[ch];
          run_ab[ch][nrun[ch]] = NEVER;
          nrun[ch]++;
        end
      end
    end
    start = st;
    abort = ab;
    @(negedge clk);
    start = '0;
    abort = '0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic scen1();
    int t;
    cfg(0, 3, 2, 1'b1);
    strobe(4'b0001, 4'b0000);
    t = cyc;
    $display("txn s1 ch0 start P=3 N=2 dir=1 at cyc %0d", t);
    check("s1_dir", 0, 64'(dir_out[0]), 64'd1);
    check("s1_busy", 0, 64'(busy[0]), 64'd1);
    wait_to(t + 2);  check("s1_step_pre", 0, 64'(step_out[0]), 64'd0);
    wait_to(t + 3);  check("s1_step_rise", 0, 64'(step_out[0]), 64'd1);
    wait_to(t + 6);  check("s1_step_low", 0, 64'(step_out[0]), 64'd0);
    wait_to(t + 8);  check("s1_rem2", 0, 64'(remaining[0 +: CW]), 64'd2);
    wait_to(t + 9);  check("s1_rem1", 0, 64'(remaining[0 +: CW]), 64'd1);
    wait_to(t + 14); check("s1_nodone", 0, 64'(done[0]), 64'd0);
    wait_to(t + 15);
    check("s1_done", 0, 64'({done[0], busy[0]}), 64'b10);
    check("s1_rem0", 0, 64'(remaining[0 +: CW]), 64'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    rst_cyc = cyc;
    @(negedge clk);

    scen1();

    cfg(1, 5, 0, 1'b1);
    strobe(4'b0010, 4'b0000);
    t = cyc;
    $display("txn s2 ch1 start N=0 at cyc %0d", t);
    check("s2_busy", 1, 64'(busy[1]), 64'd1);
    wait_to(t + 1);
    check("s2_done", 1, 64'({done[1], busy[1], step_out[1]}), 64'b100);

    cfg(2, 0, 3, 1'b0);
    strobe(4'b0100, 4'b0000);
    t = cyc;
    $display("txn s3 ch2 start P=0 N=3 at cyc %0d", t);
    wait_to(t + 3); check("s3_step_a", 2, 64'(step_out[2]), 64'd1);
    wait_to(t + 4); check("s3_step_b", 2, 64'(step_out[2]), 64'd0);
    wait_to(t + 5); check("s3_step_c", 2, 64'(step_out[2]), 64'd1);
    wait_to(t + 9); check("s3_done", 2, 64'(done[2]), 64'd1);

    cfg(3, 2, 10, 1'b1);
    strobe(4'b1000, 4'b0000);
    t = cyc;
    $display("txn s4a ch3 start P=2 N=10 at cyc %0d", t);
    wait_to(t + 9);
    strobe(4'b1000, 4'b0000);
    $display("txn s4a ch3 start while busy at cyc %0d", cyc);
    check("s4_reject", 3, 64'(reject[3]), 64'd1);
    wait_to(t + 11); check("s4_reject_1cyc", 3, 64'(reject[3]), 64'd0);
    wait_to(t + 43); check("s4_done", 3, 64'(done[3]), 64'd1);
    @(negedge clk);
    strobe(4'b1000, 4'b0000);
    t = cyc;
    $display("txn s4b ch3 start P=2 N=10 at cyc %0d", t);
    wait_to(t + 20);
    strobe(4'b0000, 4'b1000);
    $display("txn s4b ch3 abort at cyc %0d", cyc);
    check("s4_aborted", 3, 64'({aborted[3], step_out[3], busy[3], done[3]}), 64'b1000);
    check("s4_rem6", 3, 64'(remaining[3*CW +: CW]), 64'd6);
    wait_to(t + 43);
    check("s4_nodone", 3, 64'(done[3]), 64'd0);

    cfg(0, 1, 4, 1'b0); cfg(1, 2, 4, 1'b1); cfg(2, 5, 4, 1'b0); cfg(3, 7, 4, 1'b1);
    strobe(4'b1111, 4'b0000);
    t = cyc;
    $display("txn s5 all start P=1,2,5,7 N=4 at cyc %0d", t);
    wait_to(t + 11); check("s5_done0", 0, 64'(done[0]), 64'd1);
    wait_to(t + 19); check("s5_done1", 1, 64'(done[1]), 64'd1);
    wait_to(t + 43); check("s5_done2", 2, 64'(done[2]), 64'd1);
    wait_to(t + 59); check("s5_done3", 3, 64'(done[3]), 64'd1);
    strobe(4'b0001, 4'b0001);
    $display("txn s5 ch0 start+abort idle at cyc %0d", cyc);
    check("s5_idle_sa", 0, 64'({busy[0], reject[0], aborted[0], done[0]}), 64'b0000);

    cfg(1, 4, 5, 1'b1);
    strobe(4'b0010, 4'b0000);
    t = cyc;
    $display("txn s6 ch1 start P=4 N=5 at cyc %0d", t);
    wait_to(t + 4);
    check("s6_high", 1, 64'(step_out[1]), 64'd1);
    #2 reset = 1'b1;
    #1;
    $display("txn s6 async reset at cyc %0d", cyc);
    check("s6_rst_step", -1, 64'(step_out), 64'd0);
    check("s6_rst_busy", -1, 64'(busy), 64'd0);
    check("s6_rst_rem", -1, 64'(remaining), 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    rst_cyc = cyc;
    @(negedge clk);
    scen1();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
